pipe_mips32: RTL and testbench

- Five-stage in-order pipelined processor (IF, ID, EX, MEM, WB) executing a reduced 32-bit MIPS-like ISA.
- Contains its own 32x32 register file and a unified 1024x32 instruction/data memory.
- Self-contained top-level core. Programs and initial register values are loaded by hierarchical write before or at reset release.
- Runs until a HLT instruction retires.

---
 rtl/pipe_mips32.sv | 199 +++++++++++++++++++
 tb/tb_pipe_mips32.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mips32.sv
// Five-stage in-order MIPS-like core (IF/ID/EX/MEM/WB) with its own register file
// and a unified word-addressed instruction/data memory; runs until a HLT retires.
module pipe_mips32 #(
    parameter int MEM_WORDS = 1024
) (
    input  logic clk,
    input  logic rst,
    output logic halted
);
    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    logic [31:0] Mem [0:MEM_WORDS-1];
    logic [31:0] Reg [0:31];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;
    logic        hlt_seen;

    logic        vld_p0;
    logic [31:0] ir_p0, npc_p0;

    logic        vld_p1, we_p1;
    logic [5:0]  op_p1;
    logic [4:0]  rs_p1, rt_p1, dst_p1;
    logic [31:0] a_p1, b_p1, imm_p1, npc_p1;

    logic        vld_p2, we_p2, ld_p2, st_p2, hlt_p2;
    logic [4:0]  dst_p2;
    logic [31:0] res_p2, sd_p2;

    logic        vld_p3, we_p3, hlt_p3;
    logic [4:0]  dst_p3;
    logic [31:0] val_p3;

    function automatic logic is_rtype(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: is_rtype = 1'b1;
            default:                                       is_rtype = 1'b0;
        endcase
    endfunction

    function automatic logic writes_reg(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL,
            OP_ADDI, OP_SUBI, OP_SLTI, OP_LW: writes_reg = 1'b1;
            default:                          writes_reg = 1'b0;
        endcase
    endfunction

    // LW/SW reuse the adder to form the effective address.
    function automatic logic [31:0] alu(input logic [5:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] imm);
        logic signed [31:0] sa, sb, si;
        sa = a;
        sb = b;
        si = imm;
        case (op)
            OP_ADD:                   alu = a + b;
            OP_SUB:                   alu = a - b;
            OP_AND:                   alu = a & b;
            OP_OR:                    alu = a | b;
            OP_SLT:                   alu = {31'd0, sa < sb};
            OP_MUL:                   alu = a * b;
            OP_ADDI, OP_LW, OP_SW:    alu = a + imm;
            OP_SUBI:                  alu = a - imm;
            OP_SLTI:                  alu = {31'd0, sa < si};
            default:                  alu = 32'd0;
        endcase
    endfunction

    // ---- ID: decode and write-through register read ----
    logic [5:0]  op_id;
    logic [4:0]  rs_id, rt_id, rd_id, dst_id;
    logic [31:0] imm_id, rsv_id, rtv_id;
    logic        wb_we;

    assign op_id  = ir_p0[31:26];
    assign rs_id  = ir_p0[25:21];
    assign rt_id  = ir_p0[20:16];
    assign rd_id  = ir_p0[15:11];
    assign imm_id = {{16{ir_p0[15]}}, ir_p0[15:0]};
    assign dst_id = is_rtype(op_id) ? rd_id : rt_id;
    assign wb_we  = vld_p3 && we_p3 && (dst_p3 != 5'd0);

    always_comb begin
        rsv_id = Reg[rs_id];
        rtv_id = Reg[rt_id];
        if (wb_we && dst_p3 == rs_id) rsv_id = val_p3;
        if (wb_we && dst_p3 == rt_id) rtv_id = val_p3;
        if (rs_id == 5'd0) rsv_id = 32'd0;
        if (rt_id == 5'd0) rtv_id = 32'd0;
    end

    // ---- EX: operand forwarding, ALU, branch resolution ----
    logic [31:0] fa, fb, ex_res, br_target;
    logic        fwd2_ok, br_taken, id_hlt, fetch_stop;

    // A load in EX/MEM has no data yet, so its consumer falls back to older values.
    assign fwd2_ok = vld_p2 && we_p2 && !ld_p2 && (dst_p2 != 5'd0);

    always_comb begin
        fa = a_p1;
        fb = b_p1;
        if (fwd2_ok && dst_p2 == rs_p1)     fa = res_p2;
        else if (wb_we && dst_p3 == rs_p1)  fa = val_p3;
        if (fwd2_ok && dst_p2 == rt_p1)     fb = res_p2;
        else if (wb_we && dst_p3 == rt_p1)  fb = val_p3;
    end

    assign ex_res     = alu(op_p1, fa, fb, imm_p1);
    assign br_target  = npc_p1 + imm_p1;
    assign br_taken   = vld_p1 && (((op_p1 == OP_BNEQZ) && (fa != 32'd0)) ||
                                   ((op_p1 == OP_BEQZ)  && (fa == 32'd0)));
    assign id_hlt     = vld_p0 && (op_id == OP_HLT) && !br_taken;
    assign fetch_stop = hlt_seen || id_hlt;
    assign halted     = HALTED;

    always_ff @(posedge clk) begin
        if (rst) begin
            PC           <= 32'd0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            hlt_seen     <= 1'b0;
            vld_p0       <= 1'b0;
            vld_p1       <= 1'b0;
            vld_p2       <= 1'b0;
            vld_p3       <= 1'b0;
        end else if (!HALTED) begin
            TAKEN_BRANCH <= br_taken;
            hlt_seen     <= hlt_seen || id_hlt;
            HALTED       <= vld_p3 && hlt_p3;
            if (br_taken)
                PC <= br_target;
            else if (!fetch_stop)
                PC <= PC + 32'd1;
            vld_p0 <= !br_taken && !fetch_stop;
            vld_p1 <= vld_p0 && !br_taken;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
        end
    end

    always_ff @(posedge clk) begin
        if (!HALTED) begin
            // ---- IF -> ID ----
            ir_p0  <= Mem[PC[AW-1:0]];
            npc_p0 <= PC + 32'd1;
            // ---- ID -> EX ----
            op_p1  <= op_id;
            rs_p1  <= rs_id;
            rt_p1  <= rt_id;
            dst_p1 <= dst_id;
            we_p1  <= writes_reg(op_id);
            a_p1   <= rsv_id;
            b_p1   <= rtv_id;
            imm_p1 <= imm_id;
            npc_p1 <= npc_p0;
            // ---- EX -> MEM ----
            we_p2  <= we_p1;
            ld_p2  <= (op_p1 == OP_LW);
            st_p2  <= (op_p1 == OP_SW);
            hlt_p2 <= (op_p1 == OP_HLT);
            dst_p2 <= dst_p1;
            res_p2 <= ex_res;
            sd_p2  <= fb;
            // ---- MEM -> WB ----
            we_p3  <= we_p2;
            hlt_p3 <= hlt_p2;
            dst_p3 <= dst_p2;
            val_p3 <= ld_p2 ? Mem[res_p2[AW-1:0]] : res_p2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !HALTED && vld_p2 && st_p2)
            Mem[res_p2[AW-1:0]] <= sd_p2;
    end

    always_ff @(posedge clk) begin
        if (!rst && !HALTED && wb_we)
            Reg[dst_p3] <= val_p3;
    end

endmodule

// File: tb/tb_pipe_mips32.sv
// Directed bench for pipe_mips32: loads small programs, pushes expected register and
// memory contents to a scoreboard, and compares them once the core halts.
module tb_pipe_mips32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halted;
    int   checks = 0;
    int   failures = 0;

    pipe_mips32 #(.MEM_WORDS(1024)) dut (.clk(clk), .rst(rst), .halted(halted));

    always #5 clk = ~clk;

    localparam logic [5:0] OP_ADD = 6'b000000, OP_OR = 6'b000011, OP_MUL = 6'b000101;
    localparam logic [5:0] OP_LW = 6'b001000, OP_SW = 6'b001001, OP_ADDI = 6'b001010;
    localparam logic [5:0] OP_SUBI = 6'b001011, OP_BNEQZ = 6'b001101, OP_BEQZ = 6'b001110;
    localparam logic [31:0] HLT = 32'hFC00_0000;
    localparam logic [31:0] NOP = 32'hF000_0000;

    typedef struct {
        string       tag;
        bit          mem;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] prog[$];
    logic [31:0] regsnap [0:31];
    logic [31:0] memsnap [0:255];

    function automatic logic [31:0] rr(input logic [5:0] op, input int rs, input int rt, input int rd);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] ii(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d (0x%08h) expected=%0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic exp_reg(input string tag, input int idx, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.mem = 1'b0; e.idx = idx; e.val = v;
        sb.push_back(e);
    endtask

    task automatic exp_mem(input string tag, input int idx, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.mem = 1'b1; e.idx = idx; e.val = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = e.mem ? dut.Mem[e.idx] : dut.Reg[e.idx];
            check(e.tag, obs, e.val);
        end
    endtask

    // Holds reset and writes the program; registers optionally preloaded with Reg[k]=k.
    task automatic load(input bit preload);
        rst = 1'b1;
        for (int k = 0; k < 64; k++) dut.Mem[k] = NOP;
        for (int k = 0; k < prog.size(); k++) dut.Mem[k] = prog[k];
        if (preload)
            for (int k = 0; k < 32; k++) dut.Reg[k] = k;
    endtask

    task automatic release_rst(input string tag, input bit chk);
        @(posedge clk);
        @(negedge clk);
        if (chk) begin
            check({tag, "_halted"}, 32'(halted), 32'd0);
            check({tag, "_pc"}, dut.PC, 32'd0);
            check({tag, "_taken"}, 32'(dut.TAKEN_BRANCH), 32'd0);
        end
        rst = 1'b0;
    endtask

    task automatic run(input string tag, input int budget, output int taken);
        int cyc;
        cyc   = 0;
        taken = 0;
        while (!halted && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (dut.TAKEN_BRANCH) taken++;
        end
        check({tag, "_halt"}, 32'(halted), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tk;
        int diffs;
        logic [31:0] pcsnap;

        // ADD / dependency program, with reset-state checks
        prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                 32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
        load(1'b1);
        release_rst("reset", 1'b1);
        exp_reg("add_r0", 0, 0);
        exp_reg("add_r1", 1, 10);
        exp_reg("add_r2", 2, 20);
        exp_reg("add_r3", 3, 25);
        exp_reg("add_r4", 4, 30);
        exp_reg("add_r5", 5, 55);
        exp_reg("add_r6", 6, 6);
        exp_reg("add_r7", 7, 7);
        exp_reg("add_r15", 15, 7);
        run("add", 15, tk);
        drain();

        // Back-to-back forwarding, youngest producer wins
        prog = '{ii(OP_ADDI, 0, 1, 5), rr(OP_ADD, 1, 1, 2), rr(OP_ADD, 2, 1, 3),
                 ii(OP_ADDI, 0, 4, 1), ii(OP_ADDI, 0, 4, 2), rr(OP_ADD, 4, 4, 5), HLT};
        load(1'b1);
        release_rst("fwd", 1'b0);
        exp_reg("fwd_r1", 1, 5);
        exp_reg("fwd_r2", 2, 10);
        exp_reg("fwd_r3", 3, 15);
        exp_reg("fwd_r4", 4, 2);
        exp_reg("fwd_r5", 5, 4);
        run("fwd", 40, tk);
        drain();

        // Load / store with one spacer after the load
        prog = '{ii(OP_LW, 1, 2, 0), rr(OP_OR, 20, 20, 20), ii(OP_ADDI, 2, 2, 45),
                 ii(OP_SW, 1, 2, 1), HLT};
        load(1'b1);
        dut.Reg[1]   = 120;
        dut.Mem[120] = 85;
        dut.Mem[121] = 0;
        release_rst("ldst", 1'b0);
        exp_reg("ldst_r2", 2, 130);
        exp_mem("ldst_mem121", 121, 130);
        exp_mem("ldst_mem120", 120, 85);
        run("ldst", 40, tk);
        drain();

        // Taken branch flushes the two following instructions
        prog = '{ii(OP_BEQZ, 0, 0, 2), ii(OP_ADDI, 0, 5, 1), ii(OP_ADDI, 0, 6, 1),
                 ii(OP_ADDI, 0, 7, 3), HLT};
        load(1'b1);
        release_rst("flush", 1'b0);
        exp_reg("flush_r5", 5, 5);
        exp_reg("flush_r6", 6, 6);
        exp_reg("flush_r7", 7, 3);
        run("flush", 40, tk);
        check("flush_taken_cycles", tk, 1);
        drain();

        // Factorial loop of 7
        prog = '{ii(OP_LW, 10, 3, 0), rr(OP_OR, 20, 20, 20), rr(OP_MUL, 2, 3, 2),
                 ii(OP_SUBI, 3, 3, 1), ii(OP_BNEQZ, 3, 0, -3), ii(OP_ADDI, 11, 11, 1),
                 ii(OP_ADDI, 12, 12, 1), HLT};
        load(1'b1);
        dut.Reg[10]  = 200;
        dut.Mem[200] = 7;
        dut.Reg[2]   = 1;
        dut.Reg[11]  = 0;
        dut.Reg[12]  = 0;
        release_rst("fact", 1'b0);
        exp_reg("fact_r2", 2, 5040);
        exp_reg("fact_r3", 3, 0);
        exp_reg("fact_r11", 11, 1);
        exp_reg("fact_r12", 12, 1);
        run("fact", 200, tk);
        check("fact_taken_cycles", tk, 6);
        drain();

        // Frozen after halt
        pcsnap = dut.PC;
        for (int k = 0; k < 32; k++) regsnap[k] = dut.Reg[k];
        for (int k = 0; k < 256; k++) memsnap[k] = dut.Mem[k];
        repeat (20) @(posedge clk);
        #1;
        diffs = 0;
        for (int k = 0; k < 32; k++) if (dut.Reg[k] !== regsnap[k]) diffs++;
        check("freeze_regs", diffs, 0);
        diffs = 0;
        for (int k = 0; k < 256; k++) if (dut.Mem[k] !== memsnap[k]) diffs++;
        check("freeze_mem", diffs, 0);
        check("freeze_pc", dut.PC, pcsnap);
        check("freeze_halted", 32'(halted), 32'd1);

        // Reset restarts from Mem[0]; registers survive; R0 stays zero and is never forwarded
        prog = '{ii(OP_ADDI, 0, 0, 9), rr(OP_ADD, 0, 0, 9), ii(OP_ADDI, 0, 8, 4), HLT};
        load(1'b0);
        release_rst("rst2", 1'b1);
        exp_reg("rst2_r0", 0, 0);
        exp_reg("rst2_r9", 9, 0);
        exp_reg("rst2_r8", 8, 4);
        exp_reg("rst2_r2_kept", 2, 5040);
        run("rst2", 40, tk);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
